fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front end for the 5-stage RV32I pipeline. It owns the fetch PC, drives the synchronous-read instruction memory, and buffers returned instructions with their PCs in a small FIFO. The IF/ID register consumes the FIFO head under the hazard unit's stall. Branch/jump redirects from the EX-stage branch unit flush the FIFO and the in-flight request.

## Interface
Parameters:
- PC_W, 9: fetch PC / instruction memory byte-address width.
- INS_W, 32: instruction width.
- DEPTH, 4: FIFO entries. Power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- imem_addr  out  PC_W  read address to the instruction memory; equals fetch_pc.
- imem_rdata  in  INS_W  instruction returned one cycle after imem_addr is presented.
- stall  in  1  consumer stall (Reg_Stall). 1 = do not dequeue.
- redirect  in  1  taken branch/jump (PcSel). Flushes the block and reloads the PC.
- redirect_pc  in  PC_W  target PC, sampled when redirect = 1.
- halt  in  1  1 = issue no new fetch requests; in-flight data still enqueues.
- instr_valid  out  1  FIFO non-empty.
- instr  out  INS_W  head instruction; 0 when empty.
- instr_pc  out  PC_W  head PC; 0 when empty.
- occupancy  out  $clog2(DEPTH+1)  number of valid FIFO entries.

## Operation
State:
- fetch_pc.
- inflight flag and inflight_pc.
- FIFO storage, head pointer, tail pointer, count.

Request:
- req = !redirect && !halt && (count + inflight) < DEPTH.
- On req: fetch_pc ← fetch_pc + 4, taken modulo 2^PC_W (508 + 4 = 0 for PC_W = 9). inflight ← 1, inflight_pc ← fetch_pc.
- Otherwise inflight ← 0 and fetch_pc holds.

Enqueue:
- If inflight = 1 and redirect = 0, write {imem_rdata, inflight_pc} at the tail and advance the tail.
- The credit rule (count + inflight < DEPTH) guarantees enqueue never overflows.

Dequeue:
- deq = instr_valid && !stall && !redirect. Advance the head.
- Simultaneous enqueue and dequeue: count unchanged. This is legal at count = DEPTH−1 and at count = 1.
- Pointers wrap modulo DEPTH.

Redirect (priority over stall, halt and enqueue):
- Next state: count = 0, head = tail = 0, inflight = 0, fetch_pc = redirect_pc.
- The in-flight imem_rdata is discarded. No dequeue occurs in the redirect cycle.
- Outputs during the redirect cycle still reflect the pre-flush head. The consumer ignores them because it flushes IF/ID on the same signal.

Outputs:
- instr, instr_pc and instr_valid are combinational from head and count.
- occupancy = count.

Reset (reset = 0, asynchronous):
- fetch_pc = 0, inflight = 0, inflight_pc = 0, count = 0, head = tail = 0.
- All outputs read 0, including imem_addr = 0.
- Reset asserted mid-operation drops all queued and in-flight instructions immediately.

## Timing
- Edge E1 after reset release: address 0 is requested and fetch_pc becomes 4.
- Edge E2: entry 0 is enqueued; instr_valid = 1 with instr_pc = 0 from E2 onward.
- Fetch-to-valid latency: 2 edges after reset release or after a redirect edge.
- Steady-state throughput: one instruction per cycle when stall = 0.
- Stall held: the FIFO fills to DEPTH. Requests cease once count + inflight = DEPTH.
- Stall release: one dequeue per cycle; requests resume in the same cycle the credit frees.
- No combinational path from stall or redirect to imem_addr. imem_addr is a register output.

## Test plan
- Reset then free-run, memory word at address a = 0x1000 + a: instr_pc 0, 4, 8 on consecutive cycles from E2, with instr = 0x1000, 0x1004, 0x1008. No gaps.
- stall = 1 from E3 for 8 cycles: occupancy reaches 4 and holds; imem_addr freezes at 20. On release, PCs 4, 8, 12, 16, 20 stream out in order with no loss or duplication.
- redirect = 1, redirect_pc = 0x40 while count = 3 and inflight = 1: next cycle occupancy = 0, instr_valid = 0. Two edges later instr_pc = 0x40. No stale PC appears.
- redirect and stall both asserted with the FIFO full: the flush wins; occupancy = 0 and fetch_pc = target.
- Redirect to 0x1F8 (PC_W = 9), free run: instr_pc sequence 0x1F8, 0x1FC, 0x000, 0x004.
- halt = 1 mid-stream: exactly one more entry (the in-flight one) enqueues, then the FIFO drains to 0. Separately, reset pulsed low mid-stream: all outputs read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end for the 5-stage RV32I pipeline.
// Owns the fetch PC, drives a synchronous-read instruction memory and
// buffers returned instructions (with their PCs) in a small FIFO that the
// IF/ID register drains. A redirect flushes the FIFO and the in-flight
// request and reloads the PC.
module fetch_queue #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic [PC_W-1:0]              imem_addr,
   input  logic [INS_W-1:0]             imem_rdata,
   input  logic                         stall,
   input  logic                         redirect,
   input  logic [PC_W-1:0]              redirect_pc,
   input  logic                         halt,
   output logic                         instr_valid,
   output logic [INS_W-1:0]             instr,
   output logic [PC_W-1:0]              instr_pc,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

   logic [PC_W-1:0]  fetch_pc;
   logic [PC_W-1:0]  inflight_pc;
   logic             inflight;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic [INS_W-1:0] ins_mem [DEPTH];
   logic [PC_W-1:0]  pc_mem  [DEPTH];

   logic [CNT_W:0]   credit_used;
   logic             req;
   logic             enq;
   logic             deq;

   // A request is only issued when a FIFO slot is guaranteed for its data,
   // counting the entry already in flight, so enqueue can never overflow.
   assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
   assign req = !redirect && !halt && (credit_used < DEPTH_EXT);
   assign enq = inflight && !redirect;
   assign deq = (count != '0) && !stall && !redirect;

   // Fetch PC and in-flight tracking; redirect reloads the PC and drops the
   // outstanding request so its returning data is discarded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         inflight <= 1'b0;
      end else if (req) begin
         fetch_pc    <= fetch_pc + PC_W'(4);
         inflight    <= 1'b1;
         inflight_pc <= fetch_pc;
      end else begin
         inflight <= 1'b0;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a
   // power of two, and a simultaneous enqueue/dequeue leaves count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            tail <= tail + PTR_W'(1);
         end
         if (deq) begin
            head <= head + PTR_W'(1);
         end
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage needs no reset: entries are only visible while count covers them.
   always_ff @(posedge clk) begin
      if (enq) begin
         ins_mem[tail] <= imem_rdata;
         pc_mem[tail]  <= inflight_pc;
      end
   end

   assign imem_addr   = fetch_pc;
   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? ins_mem[head] : '0;
   assign instr_pc    = instr_valid ? pc_mem[head] : '0;
   assign occupancy   = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by randomized traffic for
// fetch_queue. A queue-based reference model predicts FIFO contents and the
// fetch PC; a negedge monitor compares the DUT against it every cycle.
module tb_fetch_queue;

   localparam int PC_W  = 9;
   localparam int INS_W = 32;
   localparam int DEPTH = 4;
   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [INS_W-1:0] ins;
   } entry_t;

   logic               clk;
   logic               reset;
   logic [PC_W-1:0]    imem_addr;
   logic [INS_W-1:0]   imem_rdata;
   logic               stall;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               halt;
   logic               instr_valid;
   logic [INS_W-1:0]   instr;
   logic [PC_W-1:0]    instr_pc;
   logic [OCC_W-1:0]   occupancy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   entry_t          exp_q[$];
   logic [PC_W-1:0] m_pc;
   logic [PC_W-1:0] m_inf_pc;
   bit              m_inf;
   bit              m_req;
   bit              m_deq;

   fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .occupancy   (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read instruction memory: word at address a holds 0x1000 + a
   always @(posedge clk) imem_rdata <= 32'h1000 + 32'(imem_addr);

   function automatic logic [INS_W-1:0] memWord(input logic [PC_W-1:0] a);
      return 32'h1000 + 32'(a);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit st, input bit rd, input logic [PC_W-1:0] rpc, input bit hl);
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      halt        = hl;
   endtask

   // Wait (bounded) until occupancy reaches a target value
   task automatic waitOccupancy(input int target, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (32'(occupancy) != target && n < 20);
      checkOutput(name, 32'(occupancy), 32'(target));
   endtask

   // Reference model: FIFO as a queue of expected entries, updated per edge
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q.delete();
         m_pc     = '0;
         m_inf_pc = '0;
         m_inf    = 0;
      end else if (redirect) begin
         exp_q.delete();
         m_inf = 0;
         m_pc  = redirect_pc;
      end else begin
         m_req = !halt && ((exp_q.size() + int'(m_inf)) < DEPTH);
         m_deq = (exp_q.size() != 0) && !stall;
         if (m_deq) void'(exp_q.pop_front());
         if (m_inf) exp_q.push_back('{pc: m_inf_pc, ins: memWord(m_inf_pc)});
         if (m_req) begin
            m_inf_pc = m_pc;
            m_pc     = m_pc + PC_W'(4);
            m_inf    = 1;
         end else begin
            m_inf = 0;
         end
      end
   end

   // Monitor: compare DUT outputs against the model head every cycle
   always @(negedge clk) begin
      checkOutput("mon_imem_addr", 32'(imem_addr), 32'(m_pc));
      checkOutput("mon_occupancy", 32'(occupancy), 32'(exp_q.size()));
      checkOutput("mon_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         checkOutput("mon_instr_pc", 32'(instr_pc), 32'(exp_q[0].pc));
         checkOutput("mon_instr", instr, exp_q[0].ins);
      end else begin
         checkOutput("mon_instr_pc_empty", 32'(instr_pc), 32'h0);
         checkOutput("mon_instr_empty", instr, 32'h0);
      end
   end

   // Directed scenarios, then randomized traffic
   initial begin
      logic [PC_W-1:0] p;
      logic [PC_W-1:0] pm4;
      logic [PC_W-1:0] wrap_pcs [4];

      reset = 1'b0;
      applyStimulus(0, 0, '0, 0);
      repeat (3) @(negedge clk);
      checkOutput("reset_addr", 32'(imem_addr), 32'h0);
      checkOutput("reset_valid", 32'(instr_valid), 32'h0);
      reset = 1'b1;

      // Free run from reset: E1 requests 0, E2 presents it
      @(negedge clk);
      checkOutput("e1_valid", 32'(instr_valid), 32'h0);
      checkOutput("e1_addr", 32'(imem_addr), 32'h4);
      @(negedge clk);
      checkOutput("e2_pc", 32'(instr_pc), 32'h0);
      checkOutput("e2_instr", instr, 32'h1000);
      @(negedge clk);
      checkOutput("e3_pc", 32'(instr_pc), 32'h4);
      checkOutput("e3_instr", instr, 32'h1004);

      // Stall from here: FIFO fills, fetch PC freezes at 20
      stall = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("stall_occ", 32'(occupancy), 32'(DEPTH));
      checkOutput("stall_addr", 32'(imem_addr), 32'd20);
      checkOutput("stall_head", 32'(instr_pc), 32'h4);
      stall = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         checkOutput("release_pc", 32'(instr_pc), 32'(4 + 4 * i));
      end

      // Redirect while partly full with a request in flight
      stall = 1'b1;
      waitOccupancy(3, "pre_redirect_occ");
      applyStimulus(0, 1, PC_W'(9'h040), 0);
      @(negedge clk);
      redirect = 1'b0;
      checkOutput("redir_occ", 32'(occupancy), 32'h0);
      checkOutput("redir_valid", 32'(instr_valid), 32'h0);
      checkOutput("redir_addr", 32'(imem_addr), 32'h40);
      @(negedge clk);
      checkOutput("redir_r1_valid", 32'(instr_valid), 32'h0);
      @(negedge clk);
      checkOutput("redir_r2_pc", 32'(instr_pc), 32'h40);
      checkOutput("redir_r2_instr", instr, 32'h1040);

      // Redirect together with stall on a full FIFO, then PC wrap-around
      stall = 1'b1;
      waitOccupancy(DEPTH, "full_occ");
      applyStimulus(1, 1, PC_W'(9'h1F8), 0);
      @(negedge clk);
      applyStimulus(0, 0, '0, 0);
      checkOutput("flush_occ", 32'(occupancy), 32'h0);
      checkOutput("flush_addr", 32'(imem_addr), 32'h1F8);
      @(negedge clk);
      wrap_pcs[0] = 9'h1F8;
      wrap_pcs[1] = 9'h1FC;
      wrap_pcs[2] = 9'h000;
      wrap_pcs[3] = 9'h004;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("wrap_pc", 32'(instr_pc), 32'(wrap_pcs[i]));
      end

      // Halt mid-stream: the in-flight entry lands, then the FIFO drains
      repeat (3) @(negedge clk);
      p   = imem_addr;
      pm4 = p - PC_W'(4);
      halt = 1'b1;
      @(negedge clk);
      checkOutput("halt_occ1", 32'(occupancy), 32'h1);
      checkOutput("halt_head", 32'(instr_pc), 32'(pm4));
      @(negedge clk);
      checkOutput("halt_occ0", 32'(occupancy), 32'h0);
      checkOutput("halt_addr", 32'(imem_addr), 32'(p));
      halt = 1'b0;

      // Reset pulse between edges: outputs clear immediately
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_valid", 32'(instr_valid), 32'h0);
      checkOutput("async_occ", 32'(occupancy), 32'h0);
      checkOutput("async_addr", 32'(imem_addr), 32'h0);
      checkOutput("async_pc", 32'(instr_pc), 32'h0);
      checkOutput("async_instr", instr, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         applyStimulus($urandom_range(0, 99) < 40,
                       $urandom_range(0, 99) < 5,
                       PC_W'($urandom) & ~PC_W'(3),
                       $urandom_range(0, 99) < 10);
      end
      @(negedge clk);
      applyStimulus(0, 0, '0, 0);
      repeat (10) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
